// File: rtl/tff_counter_ctrl.sv
// rtl/tff_counter_ctrl.sv - T-flip-flop bank sequenced as a programmable counter
//
// Purpose:
//   A bank of WIDTH T-flops whose toggle vector is computed each cycle by a
//   small IDLE/RUN/DONE controller. The flops only ever update as
//   count <= count ^ toggle (or clear on reset). This makes the controller
//   behave as an up or down counter with a programmable terminal value,
//   in one-shot or continuous mode.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_start   - start request, only honoured in IDLE (and only without i_stop)
//   i_stop    - abort request, honoured in IDLE and RUN
//   i_mode    - 0 one-shot, 1 continuous (latched at start)
//   i_dir     - 0 count up, 1 count down (latched at start)
//   i_mod     - terminal value (latched at start)
//   o_count   - Q vector of the T-flop bank
//   o_toggle  - T vector applied at the next rising edge
//   o_busy    - high while in RUN
//   o_tc      - high in the RUN cycle where the terminal value is on o_count
//   o_done    - high for the single DONE cycle

module tff_counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_mod,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_toggle,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] count;
  logic             mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] mod_q;

  logic             load;
  logic             tc;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] toggle_gated;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] down_mask;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] reload_val;
  logic             at_term;

  // Ripple-toggle masks: bit i toggles when every lower bit is 1 (up) or
  // 0 (down). Computed per bit against a low-bit mask rather than as a
  // carry chain so each bit is an independent reduction.
  always_comb begin
    logic [WIDTH-1:0] low_mask;
    up_mask   = '0;
    down_mask = '0;
    low_mask  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask     = (WIDTH'(1) << i) - WIDTH'(1);
      up_mask[i]   = ((count & low_mask) == low_mask);
      down_mask[i] = ((~count & low_mask) == low_mask);
    end
  end

  // Start value for a fresh start comes from the live inputs; the reload
  // value used in continuous mode comes from the settings latched at start.
  assign start_val  = i_dir ? i_mod : '0;
  assign reload_val = dir_q ? mod_q : '0;
  assign at_term    = dir_q ? (count == '0) : (count == mod_q);

  always_comb begin
    state_next = state;
    toggle     = '0;
    tc         = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        // Stop has priority over start; nothing is latched when both are high.
        if (i_start && !i_stop) begin
          load       = 1'b1;
          toggle     = count ^ start_val;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          // Abort holds the count where it is and suppresses the tc pulse.
          state_next = S_IDLE;
        end else if (at_term) begin
          tc = 1'b1;
          if (mode_q) begin
            // Reload through the T inputs rather than a parallel load path.
            toggle = count ^ reload_val;
          end else begin
            state_next = S_DONE;
          end
        end else begin
          toggle = dir_q ? down_mask : up_mask;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // While reset is held the IDLE start path could otherwise present a
  // non-zero T vector, so the output is forced to zero.
  assign toggle_gated = i_rst_n ? toggle : '0;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
      mod_q  <= '0;
    end else begin
      state <= state_next;
      count <= count ^ toggle_gated;
      if (load) begin
        mode_q <= i_mode;
        dir_q  <= i_dir;
        mod_q  <= i_mod;
      end
    end
  end

  assign o_count  = count;
  assign o_toggle = toggle_gated;
  assign o_busy   = (state == S_RUN);
  assign o_tc     = tc;
  assign o_done   = (state == S_DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb/tb_tff_counter_ctrl.sv - self-checking bench for tff_counter_ctrl

module tb_tff_counter_ctrl;

  localparam int WIDTH = 8;
  localparam int NVEC  = 23;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             mode;
  logic             dir;
  logic [WIDTH-1:0] mod;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] toggle;
  logic             busy;
  logic             tc;
  logic             done;

  int checks;
  int failures;

  tff_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_stop   (stop),
    .i_mode   (mode),
    .i_dir    (dir),
    .i_mod    (mod),
    .o_count  (count),
    .o_toggle (toggle),
    .o_busy   (busy),
    .o_tc     (tc),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [7:0] mod;
    logic [7:0] count;
    logic [7:0] toggle;
    logic       busy;
    logic       tc;
    logic       done;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic st, input logic sp, input logic md,
                              input logic dr, input logic [7:0] m,
                              input logic [7:0] c, input logic [7:0] t,
                              input logic b, input logic p, input logic d);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.dir = dr; v.mod = m;
    v.count = c;  v.toggle = t; v.busy = b; v.tc = p;  v.done = d;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [7:0] c,
                           input logic [7:0] t, input logic b, input logic p,
                           input logic d);
    check({tag, ".count"},  idx, 32'(count),  32'(c));
    check({tag, ".toggle"}, idx, 32'(toggle), 32'(t));
    check({tag, ".busy"},   idx, 32'(busy),   32'(b));
    check({tag, ".tc"},     idx, 32'(tc),     32'(p));
    check({tag, ".done"},   idx, 32'(done),   32'(d));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          st sp md dr mod    count  toggle busy tc done
    // one-shot up, mod=5; start in DONE is ignored
    vecs[0]  = mk(1, 0, 0, 0, 8'd5, 8'd0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 8'd5, 8'd0, 8'h01, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 8'd5, 8'd1, 8'h03, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 8'd5, 8'd2, 8'h01, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 8'd5, 8'd3, 8'h07, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 8'd5, 8'd4, 8'h01, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 8'd5, 8'd5, 8'h00, 1, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 8'd5, 8'd5, 8'h00, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 8'd5, 8'd5, 8'h00, 0, 0, 0);
    // continuous down, mod=3, from count 5; live input changes ignored in RUN
    vecs[9]  = mk(1, 0, 1, 1, 8'd3, 8'd5, 8'h06, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 8'd3, 8'd3, 8'h01, 1, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 8'd3, 8'd2, 8'h03, 1, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 8'd7, 8'd1, 8'h01, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 8'd7, 8'd0, 8'h03, 1, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 8'd7, 8'd3, 8'h01, 1, 0, 0);
    // stop at count 2, then start+stop together in IDLE
    vecs[15] = mk(0, 1, 0, 0, 8'd7, 8'd2, 8'h00, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 8'd7, 8'd2, 8'h00, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 8'd7, 8'd2, 8'h00, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 8'd7, 8'd2, 8'h00, 0, 0, 0);
    // one-shot up, mod=0; i_mod changed while running
    vecs[19] = mk(1, 0, 0, 0, 8'd0, 8'd2, 8'h02, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 8'd9, 8'd0, 8'h00, 1, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 8'd9, 8'd0, 8'h00, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 8'd9, 8'd0, 8'h00, 0, 0, 0);

    // Reset held with start requested and a down start value present:
    // everything must read zero.
    rst_n = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    mode  = 1'b0;
    dir   = 1'b1;
    mod   = 8'd5;
    #2;
    check_all("reset", 0, 8'd0, 8'h00, 0, 0, 0);
    next_cycle();
    check_all("reset", 1, 8'd0, 8'h00, 0, 0, 0);
    start = 1'b0;
    dir   = 1'b0;
    mod   = 8'd0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      mode  = vecs[i].mode;
      dir   = vecs[i].dir;
      mod   = vecs[i].mod;
      #1;
      check_all("vec", i, vecs[i].count, vecs[i].toggle, vecs[i].busy,
                vecs[i].tc, vecs[i].done);
      next_cycle();
    end

    // Continuous up, mod=255: wrap through the reload path.
    start = 1'b1; stop = 1'b0; mode = 1'b1; dir = 1'b0; mod = 8'd255;
    #1;
    check_all("up255_start", 0, 8'd0, 8'h00, 0, 0, 0);
    next_cycle();
    start = 1'b0;
    mod   = 8'd0;
    repeat (254) @(posedge clk);
    #1;
    check_all("up255", 254, 8'd254, 8'h01, 1, 0, 0);
    next_cycle();
    check_all("up255", 255, 8'd255, 8'hFF, 1, 1, 0);
    next_cycle();
    check_all("up255_wrap", 0, 8'd0, 8'h01, 1, 0, 0);
    next_cycle();
    check_all("up255_wrap", 1, 8'd1, 8'h03, 1, 0, 0);
    stop = 1'b1;
    #1;
    check_all("up255_stop", 0, 8'd1, 8'h00, 1, 0, 0);
    next_cycle();
    stop = 1'b0;
    #1;
    check_all("up255_stop", 1, 8'd1, 8'h00, 0, 0, 0);

    // Asynchronous reset mid-RUN, then restart on the first edge after release.
    start = 1'b1; mode = 1'b0; dir = 1'b0; mod = 8'd100;
    next_cycle();
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_all("pre_rst", 0, 8'd10, 8'h01, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst", 0, 8'd0, 8'h00, 0, 0, 0);
    start = 1'b1; mode = 1'b0; dir = 1'b0; mod = 8'd3;
    #1;
    check_all("mid_rst", 1, 8'd0, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check_all("post_rst", 0, 8'd0, 8'h00, 0, 0, 0);
    next_cycle();
    start = 1'b0;
    #1;
    check_all("restart", 0, 8'd0, 8'h01, 1, 0, 0);
    next_cycle();
    check_all("restart", 1, 8'd1, 8'h03, 1, 0, 0);
    next_cycle();
    next_cycle();
    check_all("restart", 3, 8'd3, 8'h00, 1, 1, 0);
    next_cycle();
    check_all("restart", 4, 8'd3, 8'h00, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
